// File: rtl/my_gates_bus.sv
`default_nettype none
// ============================================================================
// my_gates_bus : WIDTH-bit selectable gate unit feeding a 2-entry valid/ready
//                output buffer with per-result channel enable.  Rev 1.0
// ============================================================================
module my_gates_bus #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [SEL_W-1:0]    sel,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [CHANNELS-1:0] out_chan_en,
   output logic                out_err
);

   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_MUX  = 3'd5;
   localparam logic [2:0] OP_DMUX = 3'd6;

   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_FULL  = 2'd2;

   logic [WIDTH-1:0]    res_data;
   logic [CHANNELS-1:0] res_chan;
   logic                res_err;

   always_comb begin
      res_data = '0;
      res_chan = '1;
      res_err  = 1'b0;
      case (op)
         OP_NOT:  res_data = ~a;
         OP_AND:  res_data = a & b;
         OP_OR:   res_data = a | b;
         OP_XOR:  res_data = a ^ b;
         OP_NAND: res_data = ~(a & b);
         OP_MUX:  res_data = (sel == '0) ? a : b;
         OP_DMUX: begin
            res_data      = a;
            res_chan      = '0;
            res_chan[sel] = 1'b1;
         end
         default: begin
            // Reserved opcode: flagged result that targets no consumer.
            res_data = '0;
            res_chan = '0;
            res_err  = 1'b1;
         end
      endcase
   end

   logic [WIDTH-1:0]    data_q [2];
   logic [CHANNELS-1:0] chan_q [2];
   logic                err_q  [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;
   logic                accept;
   logic                emit;

   // Ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = rst_n && (count_q != CNT_FULL);
   assign out_valid = (count_q != CNT_EMPTY);
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (accept) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (emit) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({accept, emit})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= CNT_EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            chan_q[i] <= '0;
            err_q[i]  <= 1'b0;
         end
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (accept) begin
            data_q[wr_ptr_q] <= res_data;
            chan_q[wr_ptr_q] <= res_chan;
            err_q[wr_ptr_q]  <= res_err;
         end
      end
   end

   // Head fields are forced to zero whenever nothing is valid.
   assign out_data    = out_valid ? data_q[rd_ptr_q] : '0;
   assign out_chan_en = out_valid ? chan_q[rd_ptr_q] : '0;
   assign out_err     = out_valid ? err_q[rd_ptr_q]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_my_gates_bus.sv
`default_nettype none
// ============================================================================
// tb_my_gates_bus : self-checking bench for my_gates_bus with queue model.
//                   Rev 1.0
// ============================================================================
module tb_my_gates_bus;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int SEL_W    = 2;

   typedef struct {
      logic [WIDTH-1:0]    d;
      logic [CHANNELS-1:0] c;
      logic                e;
   } ent_t;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          op;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic [SEL_W-1:0]    sel;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_data;
   logic [CHANNELS-1:0] out_chan_en;
   logic                out_err;

   int n_cmp  = 0;
   int n_fail = 0;
   ent_t mq[$];

   my_gates_bus #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_chan_en(out_chan_en),
      .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic ent_t ref_calc(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y, input logic [SEL_W-1:0] s);
      ent_t r;
      r.c = 4'hF;
      r.e = 1'b0;
      case (o)
         3'd0: r.d = ~x;
         3'd1: r.d = x & y;
         3'd2: r.d = x | y;
         3'd3: r.d = x ^ y;
         3'd4: r.d = ~(x & y);
         3'd5: r.d = (s == 0) ? x : y;
         3'd6: begin r.d = x; r.c = 4'(2 ** int'(s)); end
         default: begin r.d = '0; r.c = 4'h0; r.e = 1'b1; end
      endcase
      return r;
   endfunction

   // One clock edge; the queue model follows the transfer rules.
   task automatic step();
      bit   acc, emt;
      ent_t e;
      acc = rst_n && in_valid && (mq.size() < 2);
      emt = rst_n && out_ready && (mq.size() > 0);
      e   = ref_calc(op, a, b, sel);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         mq.delete();
      end else begin
         if (emt) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      op = 3'd1; a = 16'h1234; b = 16'hFFFF; sel = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({in_ready, out_valid, out_data, out_chan_en, out_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: rdy=%b vld=%b data=%h chan=%b err=%b, need all 0",
                     i, in_ready, out_valid, out_data, out_chan_en, out_err);
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
      end
      step();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_op_sweep();
      logic [15:0] exp_d [8] = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0,
                                 16'h0FFF, 16'hFF00, 16'hF0F0, 16'h0000};
      logic [3:0]  exp_c [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0100, 4'h0};
      out_ready = 1'b1; a = 16'hF0F0; b = 16'hFF00; sel = 2'd2;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; op = 3'(i);
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_chan_en !== exp_c[i]
             || out_err !== (i == 7)) begin
            n_fail++;
            $display("FAIL op_sweep op%0d: vld=%b data=%h chan=%b err=%b, need 1 %h %b %b",
                     i, out_valid, out_data, out_chan_en, out_err, exp_d[i], exp_c[i], i == 7);
         end
      end
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 16'h0) begin
         n_fail++;
         $display("FAIL op_sweep_drain: vld=%b data=%h, need 0 0000", out_valid, out_data);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; a = 16'hF0F0; b = 16'hFF00; sel = '0;
      op = 3'd3; step();
      op = 3'd1; step();
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0 || out_data !== 16'h0FF0) begin
         n_fail++;
         $display("FAIL bp_full: rdy=%b data=%h, need 0 0ff0", in_ready, out_data);
      end
      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); in_valid = 1'($urandom);
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 16'h0FF0 || out_chan_en !== 4'hF) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: vld=%b data=%h chan=%b, need 1 0ff0 1111",
                     i, out_valid, out_data, out_chan_en);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hF000 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_second: vld=%b data=%h rdy=%b, need 1 f000 1",
                  out_valid, out_data, in_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_empty: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      ent_t exp_list[$];
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         op = 3'($urandom_range(0, 6)); a = 16'($urandom); b = 16'($urandom);
         sel = 2'($urandom);
         exp_list.push_back(ref_calc(op, a, b, sel));
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== exp_list[i].d
             || out_chan_en !== exp_list[i].c || out_err !== exp_list[i].e) begin
            n_fail++;
            $display("FAIL b2b word%0d: vld=%b rdy=%b data=%h chan=%b err=%b, need 1 1 %h %b %b",
                     i, out_valid, in_ready, out_data, out_chan_en, out_err,
                     exp_list[i].d, exp_list[i].c, exp_list[i].e);
         end
      end
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: vld=%b, need 0", out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd2;
      a = 16'h00AA; b = 16'h5500; step();
      a = 16'h1111; step();
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rmf_full: rdy=%b vld=%b, need 0 1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 16'h0) begin
         n_fail++;
         $display("FAIL rmf_reset: vld=%b data=%h, need 0 0000", out_valid, out_data);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_stale cyc%0d: vld=%b rdy=%b data=%h, need 0 1",
                     i, out_valid, in_ready, out_data);
         end
      end
   endtask

   task automatic test_mux_dmux();
      out_ready = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'hABCD;
      op = 3'd5; sel = 2'd0; step();
      n_cmp++;
      if (out_data !== 16'h1234 || out_chan_en !== 4'hF) begin
         n_fail++;
         $display("FAIL mux_sel0: data=%h chan=%b, need 1234 1111", out_data, out_chan_en);
      end
      sel = 2'd3; step();
      n_cmp++;
      if (out_data !== 16'hABCD || out_chan_en !== 4'hF) begin
         n_fail++;
         $display("FAIL mux_sel3: data=%h chan=%b, need abcd 1111", out_data, out_chan_en);
      end
      op = 3'd6; step();
      n_cmp++;
      if (out_data !== 16'h1234 || out_chan_en !== 4'b1000 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL dmux_sel3: data=%h chan=%b err=%b, need 1234 1000 0",
                  out_data, out_chan_en, out_err);
      end
      in_valid = 1'b0; step();
   endtask

   task automatic test_random();
      ent_t h;
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         op = 3'($urandom); a = 16'($urandom); b = 16'($urandom); sel = 2'($urandom);
         step();
         n_cmp++;
         if (mq.size() == 0) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0
                || out_chan_en !== 4'h0 || out_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rand cyc%0d empty: vld=%b rdy=%b data=%h chan=%b err=%b",
                        i, out_valid, in_ready, out_data, out_chan_en, out_err);
            end
         end else begin
            h = mq[0];
            if (out_valid !== 1'b1 || in_ready !== (mq.size() < 2) || out_data !== h.d
                || out_chan_en !== h.c || out_err !== h.e) begin
               n_fail++;
               $display("FAIL rand cyc%0d: vld=%b rdy=%b data=%h chan=%b err=%b, need 1 %b %h %b %b",
                        i, out_valid, in_ready, out_data, out_chan_en, out_err,
                        mq.size() < 2, h.d, h.c, h.e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_op_sweep();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      test_mux_dmux();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/my_gates_bus.md
Name: my_gates_bus

Overview:
- Parametrised, registered successor to the single-bit gate collection.
- Applies one selectable logic operation (NOT/AND/OR/XOR/NAND/MUX/DMUX) to WIDTH-bit operands.
- Results pass through a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between a producer of operand words and a consumer; DMUX steers the result to one of CHANNELS consumers via a one-hot enable.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1).
- CHANNELS, 4, DMUX fan-out; power of 2, >=2.
- SEL_W, $clog2(CHANNELS), width of sel (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept an operand word this cycle.
- op  in  3  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  SEL_W  MUX select / DMUX channel.
- out_valid  out  1  head result valid.
- out_ready  in  1  consumer accepts head result.
- out_data  out  WIDTH  head result.
- out_chan_en  out  CHANNELS  head channel enable.
- out_err  out  1  head result came from a reserved op.

Behaviour:
- Op codes:
  - 0 NOT: ~a.
  - 1 AND: a&b.
  - 2 OR: a|b.
  - 3 XOR: a^b.
  - 4 NAND: ~(a&b).
  - 5 MUX: (sel==0) ? a : b.
  - 6 DMUX: a.
  - 7 reserved: data 0, err=1.
- out_chan_en:
  - op 6: one-hot with bit sel set.
  - ops 0-5: all ones (broadcast).
  - op 7: all zeros.
- err=0 for ops 0-6. Each buffer entry stores {data, chan_en, err}.
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- Occupancy count 0..2. in_ready = (count<2), driven from registered state only; no combinational path from out_ready to in_ready.
- out_valid = (count>0). Head entry drives out_data/out_chan_en/out_err.
- Latency: a word accepted in cycle N is visible at the head in N+1 if the buffer was empty. No same-cycle passthrough.
- Ordering strictly FIFO; no drop, no duplication.
- Simultaneous events:
  - count=1, accept+emit: count stays 1; new word becomes head in the next cycle.
  - count=2: in_ready=0, so only emit is possible; count goes to 1.
  - count=0 with out_ready=1: nothing emitted.
- Stability: while out_valid=1 and out_ready=0, head outputs hold unchanged regardless of input activity.
- Operands and op are sampled only on accept; changes without in_valid have no effect.
- Reset (rst_n=0 at a clock edge):
  - count=0, out_valid=0, out_data=0, out_chan_en=0, out_err=0.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
  - Reset mid-operation discards both buffered entries; nothing from before reset is emitted afterwards.
- When out_valid=0, out_data, out_chan_en and out_err read 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0; after release in_ready=1, out_valid=0.
- Op sweep, out_ready=1, a=16'hF0F0, b=16'hFF00, sel=2 -> one cycle later each in turn:
  - NOT: 0F0F.
  - AND: F000.
  - OR: FFF0.
  - XOR: 0FF0.
  - NAND: 0FFF.
  - MUX: FF00, chan_en 4'b1111.
  - DMUX: F0F0, chan_en 4'b0100.
  - op 7: 0000, chan_en 0000, err=1.
- Backpressure: out_ready=0, push XOR (0FF0) then AND (F000) -> in_ready=0 after the second accept; head holds 0FF0 for 5 cycles; release out_ready -> 0FF0 then F000 in order; in_ready returns to 1.
- Concurrent accept+emit at count=1: stream 10 words with in_valid=out_ready=1 -> one result per cycle, count stays 1, output order equals input order.
- Reset mid-flight: fill both entries, assert rst_n=0 for 1 cycle -> out_valid=0 next cycle; no stale result is emitted after release.
- MUX sel=0 vs sel=3, a=1234, b=ABCD -> 1234 then ABCD; DMUX sel=3 -> chan_en 4'b1000.
